// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//
// Purpose:
//   Raster timing generator for a 640x480 @ 60 Hz style VGA output. A 320x240
//   frame source is scanned with 2x2 pixel doubling. The frame source is
//   addressed combinationally through o_x/o_y and must return the pixel on
//   i_rgb in the same cycle. Colour, sync, blank and frame-start are then
//   registered together, so they share one cycle of latency.
//
//   There is no handshake. One pixel is consumed on every clock, and the frame
//   source has no way to stall the raster.
//
// Ports:
//   i_clk          pixel clock, one pixel per cycle
//   i_rst          synchronous active-high reset
//   i_rgb[23:0]    {R,G,B} for the current o_x/o_y
//   o_x[9:0]       frame-buffer column (h_cnt/2 while visible, else 0)
//   o_y[8:0]       frame-buffer row    (v_cnt/2 while visible, else 0)
//   o_r/o_g/o_b    registered colour, forced to 0 outside the visible region
//   o_hs/o_vs      registered active-low syncs
//   o_blank_n      registered, high during the visible region
//   o_frame_start  registered one-cycle pulse on the first visible pixel
// -----------------------------------------------------------------------------
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] i_rgb,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_blank_n,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries, expressed at counter width
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_active;
  logic w_hsync;
  logic w_vsync;
  logic w_first_pixel;

  // Stage 0 decode, taken straight from the counters
  assign w_h_wrap      = (r_h_cnt == H_LAST);
  assign w_v_wrap      = (r_v_cnt == V_LAST);
  assign w_active      = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
  assign w_hsync       = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
  assign w_vsync       = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
  assign w_first_pixel = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

  // The frame-buffer address stays combinational, so the source can answer
  // on i_rgb within the same cycle. Dropping bit 0 doubles every pixel and
  // every line.
  assign o_x = w_active ? {1'b0, r_h_cnt[9:1]} : 10'd0;
  assign o_y = w_active ? {1'b0, r_v_cnt[8:1]} : 9'd0;

  // Raster counters. The vertical counter only moves on a horizontal wrap,
  // so at the end of the frame both counters return to zero together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
    end else begin
      if (w_h_wrap) begin
        r_h_cnt <= 10'd0;
        if (w_v_wrap) r_v_cnt <= 10'd0;
        else          r_v_cnt <= r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Output stage. Everything here is one cycle behind the counters. This
  // keeps colour and timing aligned at the connector. Reset forces the syncs
  // inactive, so any pulse in progress ends at once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_r           <= 8'd0;
      o_g           <= 8'd0;
      o_b           <= 8'd0;
      o_hs          <= 1'b1;
      o_vs          <= 1'b1;
      o_blank_n     <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_r           <= w_active ? i_rgb[23:16] : 8'd0;
      o_g           <= w_active ? i_rgb[15:8]  : 8'd0;
      o_b           <= w_active ? i_rgb[7:0]   : 8'd0;
      o_hs          <= ~w_hsync;
      o_vs          <= ~w_vsync;
      o_blank_n     <= w_active;
      o_frame_start <= w_first_pixel;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
//
// Instance a has the default 640x480 timing. It is driven cycle by cycle with
// random colour. A reference model derives the raster position from the
// number of cycles since reset, using plain division and modulo. For each
// cycle the model pushes the expected address and the expected registered
// outputs into queues. A separate monitor pops and compares those entries.
//
// Instance b uses a much smaller raster. This lets whole frames run quickly,
// so frame spacing, vsync length and a reset during sync can be measured
// directly.
// -----------------------------------------------------------------------------
module tb_vga_timing;

  // Default raster (instance a)
  localparam int A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
  localparam int A_VA = 480, A_VFP = 10, A_VS = 2,  A_VBP = 33;
  localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
  localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;

  // Small raster (instance b)
  localparam int B_HA = 40, B_HFP = 4, B_HS = 8, B_HBP = 8;
  localparam int B_VA = 30, B_VFP = 2, B_VS = 2, B_VBP = 4;
  localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;
  localparam int B_FRAME = B_HT * B_VT;

  // Expected registered outputs: {rgb[23:0], hs, vs, blank_n, frame_start}
  localparam logic [27:0] RST_EXP = {24'h0, 4'b1100};

  // ---------------- clock / reset ----------------
  logic clk;
  logic i_rst, i_rst_b;
  logic [23:0] i_rgb, i_rgb_b;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  logic [9:0] o_x, o_x_b;
  logic [8:0] o_y, o_y_b;
  logic [7:0] o_r, o_g, o_b, o_r_b, o_g_b, o_b_b;
  logic o_hs, o_vs, o_blank_n, o_frame_start;
  logic o_hs_b, o_vs_b, o_blank_n_b, o_frame_start_b;

  vga_timing u_dut_a (
    .i_clk(clk), .i_rst(i_rst), .i_rgb(i_rgb),
    .o_x(o_x), .o_y(o_y), .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_hs(o_hs), .o_vs(o_vs), .o_blank_n(o_blank_n),
    .o_frame_start(o_frame_start)
  );

  vga_timing #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP)
  ) u_dut_b (
    .i_clk(clk), .i_rst(i_rst_b), .i_rgb(i_rgb_b),
    .o_x(o_x_b), .o_y(o_y_b), .o_r(o_r_b), .o_g(o_g_b), .o_b(o_b_b),
    .o_hs(o_hs_b), .o_vs(o_vs_b), .o_blank_n(o_blank_n_b),
    .o_frame_start(o_frame_start_b)
  );

  // ---------------- scoreboard state ----------------
  logic [27:0] exp_q[$];
  logic [18:0] exp_xy_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;          // cycles since the last reset edge
  bit model_valid = 1'b0; // counters are known once a reset edge has occurred

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [27:0] f_reg(input int n, input logic [23:0] rgb);
    int h = n % A_HT;
    int v = (n / A_HT) % A_VT;
    bit act = (h < A_HA) && (v < A_VA);
    bit hs  = !((h >= A_HA + A_HFP) && (h < A_HA + A_HFP + A_HS));
    bit vs  = !((v >= A_VA + A_VFP) && (v < A_VA + A_VFP + A_VS));
    bit fs  = (h == 0) && (v == 0);
    return {act ? rgb : 24'h0, hs, vs, act, fs};
  endfunction

  function automatic logic [18:0] f_xy(input int n);
    int h = n % A_HT;
    int v = (n / A_HT) % A_VT;
    bit act = (h < A_HA) && (v < A_VA);
    return act ? {10'(h / 2), 9'(v / 2)} : 19'h0;
  endfunction

  function automatic logic [23:0] rand_rgb();
    return ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom());
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic [23:0] rgb);
    @(negedge clk);
    i_rst = rst;
    i_rgb = rgb;
    if (model_valid) exp_xy_q.push_back(f_xy(n_cyc));
    if (rst) begin
      exp_q.push_back(RST_EXP);
      n_cyc = 0;
      model_valid = 1'b1;
    end else begin
      exp_q.push_back(f_reg(n_cyc, rgb));
      n_cyc++;
    end
  endtask

  // ---------------- monitor (instance a) ----------------
  always begin : mon_a
    logic [27:0] e;
    logic [18:0] exy;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rgb",        {o_r, o_g, o_b}, e[27:4]);
      chk("hs",         o_hs,            e[3]);
      chk("vs",         o_vs,            e[2]);
      chk("blank_n",    o_blank_n,       e[1]);
      chk("frame_start", o_frame_start,  e[0]);
    end
    @(negedge clk);
    #1;
    if (exp_xy_q.size() > 0) begin
      exy = exp_xy_q.pop_front();
      chk("xy", {o_x, o_y}, exy);
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int k;
    int fs_cnt;
    int vs_low;
    int fs_at[3];
    bit found;

    i_rst   = 1'b1;
    i_rgb   = 24'h0;
    i_rst_b = 1'b1;
    i_rgb_b = 24'h00FF00;
    fs_at   = '{0, 0, 0};

    // Reset, then release with red on the first visible pixel
    drive(1'b1, 24'h0);
    drive(1'b1, 24'h0);
    drive(1'b0, 24'hFF0000);

    // Free-run several lines with random colour and frequent white in porches
    while (n_cyc < A_HT * 6 + 10) drive(1'b0, rand_rgb());

    // Run into the middle of hsync, then reset there
    while ((n_cyc % A_HT) != 700) drive(1'b0, rand_rgb());
    drive(1'b1, 24'hFFFFFF);

    // Restart from (0,0) with white held through a full line and the porches
    repeat (900) drive(1'b0, 24'hFFFFFF);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size() + exp_xy_q.size(), 0);

    // ---------------- instance b: frame-level timing ----------------
    repeat (2) @(posedge clk);
    #1 i_rst_b = 1'b0;
    k = 0;
    fs_cnt = 0;
    vs_low = 0;
    while (fs_cnt < 3 && k < 3 * B_FRAME + 10) begin
      @(posedge clk);
      #1;
      k++;
      if (fs_cnt == 1 && !o_vs_b) vs_low++;
      if (o_frame_start_b) begin
        fs_at[fs_cnt] = k;
        fs_cnt++;
      end
    end
    chk("b_fs_count",    fs_cnt,              3);
    chk("b_first_fs",    fs_at[0],            1);
    chk("b_frame_len_1", fs_at[1] - fs_at[0], B_FRAME);
    chk("b_frame_len_2", fs_at[2] - fs_at[1], B_FRAME);
    chk("b_vs_low",      vs_low,              B_VS * B_HT);

    // Wait for hsync and vsync to be low together, then reset
    found = 1'b0;
    for (int i = 0; i < 2 * B_FRAME && !found; i++) begin
      @(posedge clk);
      #1;
      if (!o_vs_b && !o_hs_b) found = 1'b1;
    end
    chk("b_sync_found", found, 1);
    i_rst_b = 1'b1;
    @(posedge clk);
    #1;
    chk("b_rst_hs",    o_hs_b,                1);
    chk("b_rst_vs",    o_vs_b,                1);
    chk("b_rst_blank", o_blank_n_b,           0);
    chk("b_rst_fs",    o_frame_start_b,       0);
    chk("b_rst_rgb",   {o_r_b, o_g_b, o_b_b}, 24'h0);
    i_rst_b = 1'b0;
    @(posedge clk);
    #1;
    chk("b_restart_fs",    o_frame_start_b,       1);
    chk("b_restart_blank", o_blank_n_b,           1);
    chk("b_restart_rgb",   {o_r_b, o_g_b, o_b_b}, 24'h00FF00);
    chk("b_restart_x",     o_x_b,                 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch

REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1, pixel clock (25 MHz), one pixel per cycle
- i_rst, in, 1, reset
- i_rgb, in, 24, {R,G,B} returned combinationally by the frame source for the current o_x/o_y
- o_x, out, 10, frame-buffer column, 0..319
- o_y, out, 9, frame-buffer row, 0..239
- o_r / o_g / o_b, out, 8 each, registered VGA colour
- o_hs / o_vs, out, 1 each, active-low sync
- o_blank_n, out, 1, high during the visible region
- o_frame_start, out, 1, one-cycle pulse on the first visible pixel of each frame

REQ-003 Clocking and reset SHALL be: one clock, i_clk; reset i_rst is synchronous and active-high.

Function
REQ-004 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800); it wraps to 0 after 799.

REQ-005 v_cnt SHALL increment only on a cycle where h_cnt wraps; it counts 0..V_TOTAL-1 (525) and wraps to 0 after 524.

REQ-006 Horizontal regions SHALL be:
- active: h_cnt 0..639
- front porch: 640..655
- sync: 656..751
- back porch: 752..799

REQ-007 Vertical regions SHALL be:
- active: v_cnt 0..479
- front porch: 480..489
- sync: 490..491
- back porch: 492..524

REQ-008 The stage-0 signal active SHALL be (h_cnt < H_ACTIVE) AND (v_cnt < V_ACTIVE).

REQ-009 o_x SHALL equal h_cnt[9:1] and o_y SHALL equal v_cnt[8:1] when active, giving 2x2 pixel doubling of the 320x240 image; both SHALL be 0 otherwise.

REQ-010 o_x and o_y SHALL be combinational from the counters (stage 0), so i_rgb is valid in the same cycle.

REQ-011 All other outputs SHALL be registered one stage, so colour, sync and blank are aligned with each other at latency 1 cycle after their counter values.

REQ-012 Registered outputs SHALL be loaded as follows:
- o_r/o_g/o_b <= i_rgb[23:16]/[15:8]/[7:0] when active, else 0
- o_blank_n <= active

REQ-013 o_hs SHALL be registered low exactly while h_cnt is in 656..751; o_vs SHALL be registered low exactly while v_cnt is in 490..491, for whole lines.

REQ-014 o_frame_start SHALL be registered high for exactly one cycle when h_cnt==0 and v_cnt==0 at stage 0, i.e. coincident with o_blank_n rising for the first visible pixel.

REQ-015 Counter widths SHALL be 10 bits for both h_cnt and v_cnt; there SHALL be no overflow beyond the wrap points.

REQ-016 At the frame wrap (h_cnt 799 to 0 while v_cnt 524 to 0), both counters SHALL wrap in the same cycle.

REQ-017 Each frame SHALL be exactly 420000 cycles.

Reset
REQ-018 While i_rst is high at a clock edge, the block SHALL set h_cnt=0, v_cnt=0, o_r=o_g=o_b=0, o_hs=1, o_vs=1, o_blank_n=0 and o_frame_start=0.

REQ-019 In the first cycle after i_rst falls, the counters SHALL be at (0,0); o_frame_start and o_blank_n SHALL go high on the next edge.

REQ-020 Asserting i_rst mid-frame SHALL abandon the frame immediately; no partial sync pulse SHALL continue after reset.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset release, i_rgb=24'hFF0000: o_frame_start high 1 cycle after release; o_r=8'hFF, o_g=o_b=0, o_blank_n=1.
- Free-run 800 cycles: o_blank_n high 640 cycles then low 160; o_hs low for exactly 96 consecutive cycles, beginning 657 cycles after line start (1-cycle latency).
- Free-run 2 frames: consecutive o_frame_start pulses are exactly 420000 cycles apart; o_vs is low for exactly 1600 cycles per frame.
- Coordinate check: at h_cnt=3, v_cnt=5, o_x=1 and o_y=2; at h_cnt=700, o_x=0 and o_y=0.
- Blanking colour: i_rgb held at 24'hFFFFFF through the porches: o_r/o_g/o_b=0 whenever o_blank_n=0.
- Reset mid-sync at h_cnt=700, v_cnt=491: next cycle o_hs=1, o_vs=1, o_blank_n=0; counters restart at (0,0).
